psum_acc_sequencer: RTL and testbench

Sequences the psum accumulation pass that follows PE-array computation in a cluster group. It collects per-column compute-done pulses from the three PE-array tails and raises `psum_acc_en` toward the cluster-group controller. Once the controller grants with `psum_add`, it streams tail psums, reads the matching GLB psum words, adds them with signed saturation, and writes the sums back. It pulses `psum_acc_fin` when the pass is complete. It sits between the PE-array tails, the three GLB psum SRAMs and the cluster-group controller.

---
 rtl/psum_acc_sequencer_pkg.sv | 24 ++
 rtl/psum_acc_sequencer_sat_add.sv | 24 ++
 rtl/psum_acc_sequencer.sv | 151 +++++++++++++++
 tb/tb_psum_acc_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_sequencer_pkg.sv
// Shared constants and state encoding for the psum accumulation sequencer.
package psum_acc_sequencer_pkg;

  localparam int PSUM_W_DEF = 20;
  localparam int ADDR_W_DEF = 6;
  localparam int NUM_LANES  = 3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_REQ        = 3'd1;
  localparam logic [2:0] ST_GRANT_WAIT = 3'd2;
  localparam logic [2:0] ST_ACC        = 3'd3;
  localparam logic [2:0] ST_DRAIN      = 3'd4;
  localparam logic [2:0] ST_FIN        = 3'd5;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    REQ        = ST_REQ,
    GRANT_WAIT = ST_GRANT_WAIT,
    ACC        = ST_ACC,
    DRAIN      = ST_DRAIN,
    FIN        = ST_FIN
  } state_t;

endpackage

// File: rtl/psum_acc_sequencer_sat_add.sv
// Combinational signed add of two psum lanes, clamped to the lane range.
module psum_sat_add
  import psum_acc_sequencer_pkg::*;
#(
  parameter int W = PSUM_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  logic signed [W:0] wide;

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/psum_acc_sequencer.sv
// Collects PE-tail done pulses, requests the psum pass, then streams tail psums
// through a two-stage read/add/write-back pipeline into the GLB psum SRAMs.
//
// state      | meaning
// IDLE       | gathering per-column done flags
// REQ        | one-cycle psum_acc_en, flags cleared
// GRANT_WAIT | waiting for psum_add
// ACC        | accepting tail words, issuing GLB reads
// DRAIN      | waiting for both pipeline stages to empty
// FIN        | one-cycle psum_acc_fin
module psum_acc_sequencer
  import psum_acc_sequencer_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LANES-1:0]          pe_done,
  input  logic [ADDR_W:0]               num_psum,
  input  logic                          first_pass,
  output logic                          psum_acc_en,
  input  logic                          psum_add,
  output logic                          psum_acc_fin,
  output logic                          busy,
  input  logic                          pe_psum_valid,
  output logic                          pe_psum_ready,
  input  logic [NUM_LANES*PSUM_W-1:0]   pe_psum_data,
  output logic                          glb_rd_en,
  output logic [ADDR_W-1:0]             glb_rd_addr,
  input  logic [NUM_LANES*PSUM_W-1:0]   glb_rd_data,
  output logic                          glb_wr_en,
  output logic [ADDR_W-1:0]             glb_wr_addr,
  output logic [NUM_LANES*PSUM_W-1:0]   glb_wr_data
);

  localparam int DW = NUM_LANES * PSUM_W;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] flags;
  logic [ADDR_W:0]      cnt;
  logic [ADDR_W:0]      num_lat;
  logic                 fp_lat;
  logic                 hs;

  logic                 s1_valid;
  logic [ADDR_W-1:0]    s1_addr;
  logic [DW-1:0]        s1_tail;
  logic                 s2_valid;
  logic [ADDR_W-1:0]    s2_addr;
  logic [DW-1:0]        s2_data;

  logic [DW-1:0]        glb_opnd;
  logic [DW-1:0]        sum_all;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    psum_acc_en   = 1'b0;
    psum_acc_fin  = 1'b0;
    pe_psum_ready = 1'b0;
    case (state)
      IDLE: begin
        if ((flags | pe_done) == '1) state_nxt = REQ;
      end
      REQ: begin
        psum_acc_en = 1'b1;
        state_nxt   = GRANT_WAIT;
      end
      GRANT_WAIT: begin
        if (psum_add) state_nxt = (num_psum == '0) ? FIN : ACC;
      end
      ACC: begin
        pe_psum_ready = (cnt < num_lat);
        if (cnt == num_lat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) state_nxt = FIN;
      end
      FIN: begin
        psum_acc_fin = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign hs          = pe_psum_valid & pe_psum_ready;
  assign glb_rd_en   = hs & ~fp_lat;
  assign glb_rd_addr = glb_rd_en ? cnt[ADDR_W-1:0] : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags    <= '0;
      cnt      <= '0;
      num_lat  <= '0;
      fp_lat   <= 1'b0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_tail  <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      // Done pulses only count while idle; anything later belongs to the next pass.
      if (state == IDLE)     flags <= flags | pe_done;
      else if (state == REQ) flags <= '0;

      if (state == GRANT_WAIT && psum_add) begin
        num_lat <= num_psum;
        fp_lat  <= first_pass;
        cnt     <= '0;
      end else if (hs) begin
        cnt <= cnt + 1'b1;
      end

      s1_valid <= hs;
      if (hs) begin
        s1_addr <= cnt[ADDR_W-1:0];
        s1_tail <= pe_psum_data;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_data <= sum_all;
      end
    end
  end

  // GLB read data arrives alongside stage 1, so the add happens on that cycle.
  assign glb_opnd = fp_lat ? '0 : glb_rd_data;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    psum_sat_add #(.W(PSUM_W)) u_add (
      .a   (s1_tail[k*PSUM_W +: PSUM_W]),
      .b   (glb_opnd[k*PSUM_W +: PSUM_W]),
      .sum (sum_all[k*PSUM_W +: PSUM_W])
    );
  end

  assign glb_wr_en   = s2_valid;
  assign glb_wr_addr = s2_addr;
  assign glb_wr_data = s2_data;

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Bench for psum_acc_sequencer: directed vectors, corner sequences and random
// passes checked against an arithmetic model of the accumulate/write-back rules.
module tb_psum_acc_sequencer;

  localparam int PSUM_W = 20;
  localparam int ADDR_W = 6;
  localparam int NW     = ADDR_W + 1;
  localparam int DW     = 3 * PSUM_W;
  localparam longint MAXV = (longint'(1) <<< (PSUM_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (PSUM_W - 1));

  typedef struct {
    logic [DW-1:0] tail;
    logic [DW-1:0] glb;
    logic          fp;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } wr_t;

  logic              clock;
  logic              reset;
  logic [2:0]        pe_done;
  logic [NW-1:0]     num_psum;
  logic              first_pass;
  logic              psum_acc_en;
  logic              psum_add;
  logic              psum_acc_fin;
  logic              busy;
  logic              pe_psum_valid;
  logic              pe_psum_ready;
  logic [DW-1:0]     pe_psum_data;
  logic              glb_rd_en;
  logic [ADDR_W-1:0] glb_rd_addr;
  logic [DW-1:0]     glb_rd_data;
  logic              glb_wr_en;
  logic [ADDR_W-1:0] glb_wr_addr;
  logic [DW-1:0]     glb_wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int fin_cnt = 0;
  int rd_cnt = 0;
  int fin_cyc = 0;
  bit cur_fp = 0;

  logic [DW-1:0] tail_q[$];
  wr_t           exp_q[$];
  logic [DW-1:0] glb_mem[64];
  vec_t          vecs[4];

  psum_acc_sequencer #(.PSUM_W(PSUM_W), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .pe_done       (pe_done),
    .num_psum      (num_psum),
    .first_pass    (first_pass),
    .psum_acc_en   (psum_acc_en),
    .psum_add      (psum_add),
    .psum_acc_fin  (psum_acc_fin),
    .busy          (busy),
    .pe_psum_valid (pe_psum_valid),
    .pe_psum_ready (pe_psum_ready),
    .pe_psum_data  (pe_psum_data),
    .glb_rd_en     (glb_rd_en),
    .glb_rd_addr   (glb_rd_addr),
    .glb_rd_data   (glb_rd_data),
    .glb_wr_en     (glb_wr_en),
    .glb_wr_addr   (glb_wr_addr),
    .glb_wr_data   (glb_wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PSUM_W-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return {1'b0, {(PSUM_W-1){1'b1}}};
      1:       return {1'b1, {(PSUM_W-1){1'b0}}};
      default: return PSUM_W'($urandom);
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {rand_lane(), rand_lane(), rand_lane()};
  endfunction

  function automatic logic [DW-1:0] rep3(input logic [PSUM_W-1:0] x);
    return {x, x, x};
  endfunction

  // Reference: per lane, widen to integers, add, clamp to the signed lane range.
  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] t, input logic [DW-1:0] g, input bit fp);
    logic [DW-1:0]            r;
    logic signed [PSUM_W-1:0] ta;
    logic signed [PSUM_W-1:0] ga;
    longint                   s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      ta = t[k*PSUM_W +: PSUM_W];
      ga = g[k*PSUM_W +: PSUM_W];
      s  = longint'(ta);
      if (!fp) s = s + longint'(ga);
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      r[k*PSUM_W +: PSUM_W] = PSUM_W'(s);
    end
    return r;
  endfunction

  task automatic fill_random(input int n);
    tail_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      tail_q.push_back(rand_word());
      glb_mem[i] = rand_word();
    end
  endtask

  task automatic fill_model(input int n, input bit fp);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = ADDR_W'(i);
      w.data = ref_sum(tail_q[i], glb_mem[i], fp);
      exp_q.push_back(w);
    end
  endtask

  // GLB psum SRAM: one-cycle read latency, garbage when not read.
  always @(posedge clock) begin
    glb_rd_data <= glb_rd_en ? glb_mem[glb_rd_addr] : rand_word();
  end

  always @(negedge clock) begin
    wr_t e;
    if (!reset) begin
      if (psum_acc_fin) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (psum_acc_en) en_cnt++;
      if (glb_rd_en) begin
        chk(!cur_fp && glb_rd_addr == ADDR_W'(rd_cnt), "read_addr", 64'(glb_rd_addr), 64'(rd_cnt));
        rd_cnt++;
      end
      if (glb_wr_en) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", 64'(glb_wr_addr), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk(glb_wr_addr == e.addr, "write_addr", 64'(glb_wr_addr), 64'(e.addr));
          chk(glb_wr_data == e.data, "write_data", 64'(glb_wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic run_pass(input int n, input bit fp, input int vmode,
                          input int off0, input int off1, input int off2, input int abort_at);
    int maxo, idx, first_hs, g_cyc, budget, gd;
    bit hold, aborted;
    en_cnt  = 0;
    fin_cnt = 0;
    rd_cnt  = 0;
    cur_fp  = fp;
    maxo = off0;
    if (off1 > maxo) maxo = off1;
    if (off2 > maxo) maxo = off2;

    for (int c = 0; c <= maxo; c++) begin
      @(posedge clock); #1;
      pe_done = {c == off2, c == off1, c == off0};
      @(negedge clock);
      chk(!psum_acc_en && !busy, "req_quiet", 64'({psum_acc_en, busy}), 64'(0));
    end
    @(posedge clock); #1;
    pe_done = '0;
    @(negedge clock);
    chk(psum_acc_en && busy, "req_pulse", 64'({psum_acc_en, busy}), 64'(3));

    gd = $urandom_range(0, 2);
    for (int c = 0; c < gd; c++) begin
      @(posedge clock); #1;
      num_psum   = NW'($urandom);
      first_pass = 1'($urandom);
      @(negedge clock);
      chk({psum_acc_en, busy, pe_psum_ready} == 3'b010, "grant_wait",
          64'({psum_acc_en, busy, pe_psum_ready}), 64'(2));
    end

    @(posedge clock); #1;
    psum_add   = 1'b1;
    num_psum   = NW'(n);
    first_pass = fp;
    g_cyc      = cyc;
    hold       = 1'($urandom);
    idx        = 0;
    first_hs   = -1;
    budget     = 0;
    aborted    = 0;

    // Feed tails; control inputs are scrambled after the grant to prove they were latched.
    while (idx < n && budget < 8 * n + 20 && !aborted) begin
      @(posedge clock); #1;
      pe_psum_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (budget % 2 == 0) : 1'($urandom);
      pe_psum_data  = pe_psum_valid ? tail_q[idx] : rand_word();
      pe_done       = 3'($urandom);
      num_psum      = NW'($urandom);
      first_pass    = 1'($urandom);
      psum_add      = hold;
      @(negedge clock);
      if (pe_psum_valid && pe_psum_ready) begin
        if (first_hs < 0) first_hs = cyc;
        idx++;
      end
      if (abort_at >= 0 && idx == abort_at) aborted = 1;
      budget++;
    end

    if (aborted) begin
      #1 reset = 1'b1;
      #1;
      chk({psum_acc_en, psum_acc_fin, busy, pe_psum_ready, glb_rd_en, glb_rd_addr,
           glb_wr_en, glb_wr_addr} == '0, "reset_async_ctrl",
          64'({psum_acc_en, psum_acc_fin, busy, pe_psum_ready, glb_rd_en, glb_rd_addr,
               glb_wr_en, glb_wr_addr}), 64'(0));
      chk(glb_wr_data == '0, "reset_async_data", 64'(glb_wr_data), 64'(0));
      exp_q.delete();
      @(posedge clock); #1;
      reset         = 1'b0;
      pe_psum_valid = 1'b0;
      pe_done       = '0;
      psum_add      = 1'b0;
      repeat (12) @(negedge clock);
      chk(fin_cnt == 0 && !busy, "abort_no_fin", 64'(fin_cnt), 64'(0));
      return;
    end

    chk(idx == n, "feed_count", 64'(idx), 64'(n));
    @(posedge clock); #1;
    pe_psum_valid = 1'b0;
    pe_done       = '0;
    psum_add      = 1'b0;
    budget = 0;
    while (fin_cnt == 0 && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    chk(fin_cnt == 1, "fin_seen", 64'(fin_cnt), 64'(1));
    if (n == 0)
      chk(fin_cyc - g_cyc == 1, "fin_zero_latency", 64'(fin_cyc - g_cyc), 64'(1));
    else if (vmode == 0)
      chk(fin_cyc - first_hs == n + 3, "fin_latency", 64'(fin_cyc - first_hs), 64'(n + 3));
    @(negedge clock);
    @(negedge clock);
    chk(exp_q.size() == 0, "writes_done", 64'(exp_q.size()), 64'(0));
    chk(rd_cnt == (fp ? 0 : n), "read_count", 64'(rd_cnt), 64'(fp ? 0 : n));
    chk(en_cnt == 1 && fin_cnt == 1 && !busy, "pulse_once",
        64'({en_cnt[7:0], fin_cnt[7:0], busy}), 64'({8'd1, 8'd1, 1'b0}));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: run exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t wi;
    int  n;
    int  vm;
    bit  fp;

    // Saturation edges and first-pass identity, lanes written {lane2, lane1, lane0}.
    vecs[0] = '{tail: {20'h00003, 20'h80000, 20'h7FFFF}, glb: {20'hFFFF9, 20'hFFFFF, 20'h00005},
                fp: 1'b0, exp: {20'hFFFFC, 20'h80000, 20'h7FFFF}};
    vecs[1] = '{tail: {20'h00000, 20'hFFFFF, 20'h12345}, glb: {20'h7FFFF, 20'h7FFFF, 20'h7FFFF},
                fp: 1'b1, exp: {20'h00000, 20'hFFFFF, 20'h12345}};
    vecs[2] = '{tail: {20'h40000, 20'h40000, 20'hFFFF0}, glb: {20'h40000, 20'h3FFFF, 20'h00010},
                fp: 1'b0, exp: {20'h7FFFF, 20'h7FFFF, 20'h00000}};
    vecs[3] = '{tail: {20'h7FFFF, 20'hC0000, 20'hC0000}, glb: {20'h80000, 20'hBFFFF, 20'hC0000},
                fp: 1'b0, exp: {20'hFFFFF, 20'h80000, 20'h80000}};

    reset         = 1'b1;
    pe_done       = '0;
    num_psum      = '0;
    first_pass    = 1'b0;
    psum_add      = 1'b0;
    pe_psum_valid = 1'b0;
    pe_psum_data  = '0;

    repeat (2) @(negedge clock);
    chk({psum_acc_en, psum_acc_fin, busy, pe_psum_ready, glb_rd_en, glb_rd_addr,
         glb_wr_en, glb_wr_addr} == '0, "reset_ctrl",
        64'({psum_acc_en, psum_acc_fin, busy, pe_psum_ready, glb_rd_en, glb_rd_addr,
             glb_wr_en, glb_wr_addr}), 64'(0));
    chk(glb_wr_data == '0, "reset_data", 64'(glb_wr_data), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk(!busy && !psum_acc_en, "post_reset_idle", 64'({busy, psum_acc_en}), 64'(0));

    // Basic pass: GLB holds 100 per lane, tails 1..4, sums 101..104.
    tail_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tail_q.push_back(rep3(PSUM_W'(i + 1)));
      glb_mem[i] = rep3(PSUM_W'(100));
      wi.addr = ADDR_W'(i);
      wi.data = rep3(PSUM_W'(101 + i));
      exp_q.push_back(wi);
    end
    run_pass(4, 1'b0, 0, 2, 5, 9, -1);

    for (int v = 0; v < 4; v++) begin
      tail_q.delete();
      exp_q.delete();
      tail_q.push_back(vecs[v].tail);
      glb_mem[0] = vecs[v].glb;
      wi.addr = '0;
      wi.data = vecs[v].exp;
      exp_q.push_back(wi);
      run_pass(1, vecs[v].fp, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // First pass: written data is the tail data, whatever the GLB holds.
    fill_random(5);
    for (int i = 0; i < 5; i++) begin
      wi.addr = ADDR_W'(i);
      wi.data = tail_q[i];
      exp_q.push_back(wi);
    end
    run_pass(5, 1'b1, 2, 0, 3, 1, -1);

    fill_random(0);
    run_pass(0, 1'b0, 0, 1, 1, 1, -1);

    fill_random(6);
    fill_model(6, 1'b0);
    run_pass(6, 1'b0, 1, 4, 0, 2, -1);

    fill_random(8);
    fill_model(8, 1'b0);
    run_pass(8, 1'b0, 0, 0, 1, 2, 3);

    for (int r = 0; r < 12; r++) begin
      n  = (r == 11) ? 64 : int'($urandom_range(0, 16));
      fp = ($urandom_range(0, 3) == 0);
      vm = int'($urandom_range(0, 2));
      fill_random(n);
      fill_model(n, fp);
      run_pass(n, fp, vm, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
